tdm_demultiplexer: RTL and testbench
====================================

Name: tdm_demultiplexer

Overview:
- Receive end of a 4-channel time-division link; the transmit side serialises four 4-bit channels through a 2-bit select.
- Takes one beat per slot on a single bus, tracks frame alignment from a start-of-frame marker, and steers each beat into one of four registered channel outputs.
- Reports frame completion and alignment errors.

Parameters:
- WIDTH, 4, data width of each beat and of each channel output.
- Channel count is fixed at 4; slot index is 2 bits.

Ports:
- clk_n  input  1  clock; all logic on rising edge.
- reset_n  input  1  reset; synchronous, active-high despite the suffix.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  start of frame; qualifies the beat as slot 0. Ignored when in_valid=0.
- in_data  input  WIDTH  beat payload.
- output1  output  WIDTH  channel 0 data (slot 0).
- output2  output  WIDTH  channel 1 data (slot 1).
- output3  output  WIDTH  channel 2 data (slot 2).
- output4  output  WIDTH  channel 3 data (slot 3).
- out_valid  output  4  bit i pulses for one cycle when channel i+1 output updates.
- frame_done  output  1  one-cycle pulse when slot 3 of an aligned frame is written.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high while in the RUN state.
- slot  output  2  next expected slot index.

Behaviour:
- Reset (reset_n=1 at edge): output1..4=0, out_valid=0, frame_done=0, sync_err=0, state=IDLE, slot=0, locked=0. Reset takes priority over every other event and discards any partial frame.
- IDLE:
  - Beats with in_valid=1 and in_sof=0 are dropped silently; no sync_err.
  - Beat with in_valid=1 and in_sof=1: write output1, slot<=1, state<=RUN.
- RUN, with in_valid=1:
  - in_sof=1 and slot=0: normal frame start; write output1, slot<=1.
  - in_sof=0 and slot!=0: write output[slot+1], slot<=slot+1 (wraps 3->0).
  - slot=3 write: also pulse frame_done.
  - in_sof=1 and slot!=0 (early SOF): pulse sync_err; partial frame abandoned without frame_done; beat written to output1, slot<=1; stay in RUN.
  - in_sof=0 and slot=0 (missing SOF): pulse sync_err; beat dropped; state<=IDLE, slot<=0.
- in_valid=0: no state change and no pulses; outputs hold. Idle gaps between beats are legal anywhere in a frame.
- Latency: a beat sampled at edge N updates the selected output after edge N. Its out_valid bit, frame_done and sync_err are high for the cycle following edge N only.
- Outputs not being written always hold their previous value.
- locked equals (state==RUN).

Optional Feature:
- Macro: TDM_DEMUX_FRAME_LATCH_EN.
- Defined:
  - Beats go into four internal shadow registers.
  - output1..4 all update together, from the shadows, on the same edge that raises frame_done.
  - out_valid=4'b1111 for that cycle only.
  - Aborted or partial frames never reach the outputs.
  - sync_err, locked and slot behave exactly as without the macro.
- Undefined: per-slot update as described in Behaviour; no shadow registers.

Decomposition:
- Package tdm_pkg:
  - SLOT_W=2, NUM_CH=4.
  - State enum {ST_IDLE, ST_RUN}.
  - Slot index typedef.
- The transmit-side multiplexer shares tdm_pkg.
- Sub-module tdm_slot_tracker holds the state machine, slot counter and error detection. It outputs a one-hot write-enable, frame_done and sync_err.
- The top level holds only the data and shadow registers.

Test Plan:
1. Reset, then beats (sof=1,1),(0,2),(0,3),(0,4) on consecutive cycles -> output1..4=1,2,3,4; out_valid one-hot 0001,0010,0100,1000 on successive cycles; frame_done pulses once with the 4th update; locked=1.
2. Same frame with in_valid=0 for 3 cycles between beats 2 and 3 -> identical final outputs; no pulses during the gap.
3. Aligned, then (1,5),(0,6),(1,7) -> sync_err pulses on the 3rd beat; output1=7; slot=1; no frame_done.
4. Aligned at slot 0, then beat (0,9) -> sync_err pulse; locked=0; outputs unchanged. Further non-SOF beats are ignored with no sync_err.
5. Mid-frame after 2 beats, assert reset_n for 1 cycle -> all outputs 0, slot=0, locked=0. The next non-SOF beat is dropped.
6. With TDM_DEMUX_FRAME_LATCH_EN: frame (1,A),(0,B),(0,C),(0,D) -> outputs stay 0 until the 4th beat, then A,B,C,D together with out_valid=1111. A frame aborted by an early SOF leaves the outputs unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (transmit mux and receive demux).
package tdm_pkg;

  localparam int SLOT_W = 2;
  localparam int NUM_CH = 4;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] slot_onehot(input slot_t s);
    logic [NUM_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_slot_tracker.sv
// Frame alignment tracker: follows SOF markers, counts slots, flags alignment errors.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | not aligned; waiting for a beat carrying SOF
//   ST_RUN  | aligned; slot_q is the slot index the next beat must carry
module tdm_slot_tracker
  import tdm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              sof_i,
  output logic [NUM_CH-1:0] wr_en_o,
  output logic              frame_done_o,
  output logic              sync_err_o,
  output logic              locked_o,
  output slot_t             slot_o
);

  state_e state_q;
  slot_t  slot_q;
  logic   frame_done_q;
  logic   sync_err_q;

  // Write enable is combinational so the data register captures the same beat.
  always_comb begin
    wr_en_o = '0;
    if (valid_i) begin
      if (sof_i) begin
        wr_en_o = slot_onehot(slot_t'(0));
      end else if (state_q == ST_RUN && slot_q != slot_t'(0)) begin
        wr_en_o = slot_onehot(slot_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (valid_i) begin
        unique case (state_q)
          ST_IDLE: begin
            if (sof_i) begin
              state_q <= ST_RUN;
              slot_q  <= slot_t'(1);
            end
          end
          ST_RUN: begin
            if (sof_i) begin
              // Early SOF abandons the partial frame but stays aligned.
              sync_err_q <= (slot_q != slot_t'(0));
              slot_q     <= slot_t'(1);
            end else if (slot_q == slot_t'(0)) begin
              sync_err_q <= 1'b1;
              state_q    <= ST_IDLE;
              slot_q     <= '0;
            end else begin
              frame_done_q <= (slot_q == slot_t'(NUM_CH - 1));
              slot_q       <= slot_q + slot_t'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
          end
        endcase
      end
    end
  end

  assign frame_done_o = frame_done_q;
  assign sync_err_o   = sync_err_q;
  assign locked_o     = (state_q == ST_RUN);
  assign slot_o       = slot_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// Receive-side TDM demultiplexer: steers beats into four registered channel outputs.
// Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames at once from shadow registers.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk_n,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  output1,
  output logic [WIDTH-1:0]  output2,
  output logic [WIDTH-1:0]  output3,
  output logic [WIDTH-1:0]  output4,
  output logic [NUM_CH-1:0] out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
);

  logic [NUM_CH-1:0] wr_en;
  slot_t             slot_w;

  logic [WIDTH-1:0]  out_q [NUM_CH];
  logic [WIDTH-1:0]  out_d [NUM_CH];
  logic [NUM_CH-1:0] out_valid_q;
  logic [NUM_CH-1:0] out_valid_d;

  tdm_slot_tracker u_tracker (
    .clk_i        (clk_n),
    .rst_i        (reset_n),
    .valid_i      (in_valid),
    .sof_i        (in_sof),
    .wr_en_o      (wr_en),
    .frame_done_o (frame_done),
    .sync_err_o   (sync_err),
    .locked_o     (locked),
    .slot_o       (slot_w)
  );

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  // The last slot bypasses the shadows and goes straight to its output.
  logic [WIDTH-1:0] shadow_q [NUM_CH-1];
  logic [WIDTH-1:0] shadow_d [NUM_CH-1];

  always_comb begin
    for (int i = 0; i < NUM_CH - 1; i++) begin
      shadow_d[i] = wr_en[i] ? in_data : shadow_q[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = out_q[i];
    end
    out_valid_d = '0;
    if (wr_en[NUM_CH-1]) begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
        out_d[i] = shadow_q[i];
      end
      out_d[NUM_CH-1] = in_data;
      out_valid_d     = '1;
    end
  end

  always_ff @(posedge clk_n) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = wr_en[i] ? in_data : out_q[i];
    end
    out_valid_d = wr_en;
  end
`endif

  always_ff @(posedge clk_n) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        out_q[i] <= '0;
      end
      out_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        out_q[i] <= out_d[i];
      end
      out_valid_q <= out_valid_d;
    end
  end

  assign output1   = out_q[0];
  assign output2   = out_q[1];
  assign output3   = out_q[2];
  assign output4   = out_q[3];
  assign out_valid = out_valid_q;
  assign slot      = slot_w;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer: frame-level reference model plus directed literals.
module tb_tdm_demultiplexer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] output1, output2, output3, output4;
  logic [3:0]   out_valid;
  logic         frame_done, sync_err, locked;
  logic [1:0]   slot;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk_n      (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .output1    (output1),
    .output2    (output2),
    .output3    (output3),
    .output4    (output4),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked),
    .slot       (slot)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks "aligned?" and "position in frame" as plain integers.
  bit          m_aligned;
  int          m_pos;
  logic [W-1:0] m_out [4];
  logic [W-1:0] m_frame [4];
  logic [3:0]  m_ov;
  bit          m_fd, m_se;

  function automatic void m_accept(input int k, input logic [W-1:0] d);
    m_frame[k] = d;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    if (k == 3) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
      m_ov = 4'hF;
    end
`else
    m_out[k] = d;
    m_ov     = 4'(1 << k);
`endif
    if (k == 3) m_fd = 1'b1;
    m_pos = (k + 1) % 4;
  endfunction

  always @(posedge clk) begin
    if (reset_n) begin
      m_aligned = 1'b0;
      m_pos     = 0;
      for (int i = 0; i < 4; i++) begin
        m_out[i]   = '0;
        m_frame[i] = '0;
      end
      m_ov = '0; m_fd = 1'b0; m_se = 1'b0;
    end else begin
      m_ov = '0; m_fd = 1'b0; m_se = 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          if (m_aligned && m_pos != 0) m_se = 1'b1;
          m_aligned = 1'b1;
          m_accept(0, in_data);
        end else if (m_aligned) begin
          if (m_pos == 0) begin
            m_se      = 1'b1;
            m_aligned = 1'b0;
          end else begin
            m_accept(m_pos, in_data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("output1", output1, m_out[0]);
      check("output2", output2, m_out[1]);
      check("output3", output3, m_out[2]);
      check("output4", output4, m_out[3]);
      check("out_valid", out_valid, m_ov);
      check("frame_done", frame_done, m_fd);
      check("sync_err", sync_err, m_se);
      check("locked", locked, m_aligned);
      check("slot", slot, m_pos);
    end
  end

  task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0; in_sof = 1'b0;
    reset_n  = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    reset_n = 1'b0;
  endtask

  initial begin
    do_reset(2);
    cmp_en = 1'b1;
    check("rst_output1", output1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_slot", slot, 0);

`ifndef TDM_DEMUX_FRAME_LATCH_EN
    // Test 1: aligned frame on consecutive cycles
    beat(1, 1, 4'd1); check("t1_ov0", out_valid, 4'b0001);
    beat(1, 0, 4'd2); check("t1_ov1", out_valid, 4'b0010);
    beat(1, 0, 4'd3); check("t1_ov2", out_valid, 4'b0100);
    check("t1_fd_early", frame_done, 0);
    beat(1, 0, 4'd4); check("t1_ov3", out_valid, 4'b1000);
    check("t1_fd", frame_done, 1);
    check("t1_o1", output1, 1); check("t1_o2", output2, 2);
    check("t1_o3", output3, 3); check("t1_o4", output4, 4);
    check("t1_locked", locked, 1);
    beat(0, 0, 4'd0); check("t1_fd_once", frame_done, 0);

    // Test 2: idle gap mid-frame
    beat(1, 1, 4'd1); beat(1, 0, 4'd2);
    repeat (3) begin
      beat(0, 0, 4'hF);
      check("t2_gap_ov", out_valid, 0);
      check("t2_gap_fd", frame_done, 0);
    end
    beat(1, 0, 4'd3); beat(1, 0, 4'd4);
    check("t2_fd", frame_done, 1);
    check("t2_o3", output3, 3); check("t2_o4", output4, 4);

    // Test 3: early SOF
    beat(1, 1, 4'd5); beat(1, 0, 4'd6); beat(1, 1, 4'd7);
    check("t3_se", sync_err, 1); check("t3_fd", frame_done, 0);
    check("t3_o1", output1, 7); check("t3_slot", slot, 1);
    check("t3_o2", output2, 6); check("t3_locked", locked, 1);

    // Test 4: missing SOF at slot 0
    beat(1, 0, 4'd10); beat(1, 0, 4'd11); beat(1, 0, 4'd12);
    check("t4_fd", frame_done, 1); check("t4_slot0", slot, 0);
    beat(1, 0, 4'd9);
    check("t4_se", sync_err, 1); check("t4_locked", locked, 0);
    check("t4_o1", output1, 7); check("t4_o4", output4, 12);
    check("t4_ov", out_valid, 0);
    beat(1, 0, 4'd3);
    check("t4_ignored_se", sync_err, 0); check("t4_ignored_o1", output1, 7);

    // Test 5: reset mid-frame, then a non-SOF beat is dropped
    beat(1, 1, 4'd1); beat(1, 0, 4'd2);
    do_reset(1);
    check("t5_o1", output1, 0); check("t5_o2", output2, 0);
    check("t5_slot", slot, 0); check("t5_locked", locked, 0);
    beat(1, 0, 4'd5);
    check("t5_drop_o1", output1, 0); check("t5_drop_ov", out_valid, 0);
    check("t5_drop_se", sync_err, 0);
`else
    // Test 6: whole-frame publication
    beat(1, 1, 4'hA); check("t6_hold0", output1, 0);
    beat(1, 0, 4'hB); check("t6_hold1", out_valid, 0);
    beat(1, 0, 4'hC); check("t6_hold2", output2, 0);
    beat(1, 0, 4'hD);
    check("t6_ov", out_valid, 4'hF); check("t6_fd", frame_done, 1);
    check("t6_o1", output1, 4'hA); check("t6_o2", output2, 4'hB);
    check("t6_o3", output3, 4'hC); check("t6_o4", output4, 4'hD);
    beat(1, 1, 4'd1); beat(1, 0, 4'd2); beat(1, 1, 4'd3);
    check("t6_abort_se", sync_err, 1);
    check("t6_abort_o1", output1, 4'hA); check("t6_abort_o2", output2, 4'hB);
    check("t6_abort_ov", out_valid, 0);
    beat(1, 0, 4'd4); beat(1, 0, 4'd5); beat(1, 0, 4'd6);
    check("t6_f2_o1", output1, 3); check("t6_f2_o4", output4, 6);
`endif

    // Extra: several back-to-back frames with scattered gaps, model-checked
    beat(1, 1, 4'h8);
    for (int i = 0; i < 12; i++) begin
      if (i % 5 == 2) beat(0, 0, 4'h0);
      beat(1, (i % 4) == 3, 4'(i + 3));
    end
    beat(0, 0, 4'h0);
    beat(0, 0, 4'h0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
